// File: rtl/rv32_seq_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encodings,
// trap-cause codes, supported opcodes and small decode helpers.
package rv32_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_FETCH_ERR = 2'b01,
    CAUSE_FETCH_TMO = 2'b10,
    CAUSE_ILLEGAL   = 2'b11
  } cause_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  // Only register-register and register-immediate ALU ops are executed.
  function automatic logic opc_supported(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
  endfunction

  // Writes to x0 are architecturally discarded, so never raise reg_we for them.
  function automatic logic rd_nonzero(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/rv32_seq_ctrl_fetch_tmo.sv
// Fetch timeout counter: counts FETCH cycles without an ack and flags the
// last permitted cycle so the sequencer can trap instead of waiting forever.
module rv32_seq_ctrl_fetch_tmo #(
  parameter int unsigned TMO_W   = 4,
  parameter int unsigned TMO_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO_MAX - 1);
  localparam logic [TMO_W-1:0] ONE   = TMO_W'(1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Clear has priority so a new fetch always starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rv32_seq_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath. Walks FETCH/DECODE/EXEC/WB,
// gates PC advance and regfile writes, holds the instruction register and
// offers halt/single-step debug control plus a sticky trap.
module rv32_seq_ctrl #(
  parameter int unsigned TMO_W   = 4,
  parameter int unsigned TMO_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  input  logic [31:0] instr_i,
  output logic [31:0] ir_o,
  output logic        ir_load_o,
  output logic        pc_en_o,
  output logic        reg_we_o,
  input  logic        halt_req_i,
  input  logic        step_req_i,
  output logic        halted_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [2:0]  state_o,
  output logic [31:0] retired_o
);

  import rv32_seq_ctrl_pkg::*;

  state_e      state_q,     state_d;
  logic [31:0] ir_q,        ir_d;
  logic [31:0] retired_q,   retired_d;
  cause_e      cause_q,     cause_d;
  logic        step_mode_q, step_mode_d;
  logic        imem_req_q,  imem_req_d;
  logic        ir_load_q,   ir_load_d;
  logic        pc_en_q,     pc_en_d;
  logic        reg_we_q,    reg_we_d;
  logic        halted_q,    halted_d;
  logic        trap_q,      trap_d;

  logic tmo_expire;
  logic tmo_clr;
  logic tmo_inc;

  assign tmo_inc = (state_q == ST_FETCH) && !imem_ack_i;
  assign tmo_clr = (state_q != ST_FETCH) || imem_ack_i;

  rv32_seq_ctrl_fetch_tmo #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_fetch_tmo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmo_clr),
    .inc_i    (tmo_inc),
    .expire_o (tmo_expire)
  );

  // Next-state and next-output decode; outputs are derived from the next state
  // so they are registered and valid in the same cycle as the state they belong to.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    cause_d     = cause_q;
    step_mode_d = step_mode_q;

    case (state_q)
      ST_IDLE: begin
        if (halt_req_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A late ack on the expiry cycle still wins over the timeout.
        if (imem_ack_i) begin
          if (imem_err_i) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_FETCH_ERR;
          end else begin
            state_d = ST_DECODE;
            ir_d    = instr_i;
          end
        end else if (tmo_expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TMO;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opc_supported(ir_q[6:0])) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        retired_d   = retired_q + 32'd1;
        step_mode_d = 1'b0;
        if (halt_req_i || step_mode_q) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        // A step request beats a simultaneous release of halt.
        if (step_req_i) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b1;
        end else if (!halt_req_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    imem_req_d = (state_d == ST_FETCH);
    ir_load_d  = (state_q == ST_FETCH) && (state_d == ST_DECODE);
    pc_en_d    = (state_d == ST_WB);
    reg_we_d   = (state_d == ST_WB) && rd_nonzero(ir_d[11:7]);
    halted_d   = (state_d == ST_HALT);
    trap_d     = (state_d == ST_TRAP);
  end

  // Sequencer state and registered outputs; reset abandons any in-flight instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ir_q        <= 32'd0;
      retired_q   <= 32'd0;
      cause_q     <= CAUSE_NONE;
      step_mode_q <= 1'b0;
      imem_req_q  <= 1'b0;
      ir_load_q   <= 1'b0;
      pc_en_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      cause_q     <= cause_d;
      step_mode_q <= step_mode_d;
      imem_req_q  <= imem_req_d;
      ir_load_q   <= ir_load_d;
      pc_en_q     <= pc_en_d;
      reg_we_q    <= reg_we_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
    end
  end

  assign imem_req_o   = imem_req_q;
  assign ir_o         = ir_q;
  assign ir_load_o    = ir_load_q;
  assign pc_en_o      = pc_en_q;
  assign reg_we_o     = reg_we_q;
  assign halted_o     = halted_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_rv32_seq_ctrl.sv
// Self-checking bench for rv32_seq_ctrl: a table of single-instruction
// vectors plus hand-written timeout, halt/step and mid-instruction reset runs.
// Expected write-backs and traps are queued when the fetch is answered and
// retired against the DUT's pc_en / trap outputs.
module tb_rv32_seq_ctrl;

  localparam int TMO_W   = 4;
  localparam int TMO_MAX = 15;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        imem_ack = 1'b0;
  logic        imem_err = 1'b0;
  logic [31:0] instr    = 32'd0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;

  logic        imem_req_o;
  logic [31:0] ir_o;
  logic        ir_load_o;
  logic        pc_en_o;
  logic        reg_we_o;
  logic        halted_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
  logic [2:0]  state_o;
  logic [31:0] retired_o;

  always #5 clk = ~clk;

  rv32_seq_ctrl #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req_o),
    .imem_ack_i   (imem_ack),
    .imem_err_i   (imem_err),
    .instr_i      (instr),
    .ir_o         (ir_o),
    .ir_load_o    (ir_load_o),
    .pc_en_o      (pc_en_o),
    .reg_we_o     (reg_we_o),
    .halt_req_i   (halt_req),
    .step_req_i   (step_req),
    .halted_o     (halted_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o),
    .state_o      (state_o),
    .retired_o    (retired_o)
  );

  typedef struct {
    logic        is_trap;
    logic [1:0]  cause;
    logic        we;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    int          waits;
    logic        err;
    logic        trap;
    logic [1:0]  cause;
    logic        we;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[6];

  int   checks    = 0;
  int   errors    = 0;
  int   cyc_n     = 0;
  int   wb_cyc    = 0;
  int   pc_cnt    = 0;
  int   we_cnt    = 0;
  logic trap_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=no event", nm, act);
  endtask

  function automatic exp_t mk_ret(input logic [31:0] w, input logic we);
    exp_t e;
    e.is_trap = 1'b0;
    e.cause   = 2'b00;
    e.we      = we;
    e.ir      = w;
    return e;
  endfunction

  function automatic exp_t mk_trap(input logic [1:0] cause);
    exp_t e;
    e.is_trap = 1'b1;
    e.cause   = cause;
    e.we      = 1'b0;
    e.ir      = 32'd0;
    return e;
  endfunction

  // Scoreboard side: retire queued expectations on write-back and trap entry.
  task automatic observe();
    exp_t e;
    if (pc_en_o === 1'b1) begin
      pc_cnt++;
      wb_cyc = cyc_n;
      if (sbq.size() == 0) begin
        unexpected("wb_unexpected", ir_o);
      end else begin
        e = sbq.pop_front();
        chk("wb_kind", {31'd0, e.is_trap}, 32'd0);
        chk("wb_reg_we", {31'd0, reg_we_o}, {31'd0, e.we});
        chk("wb_ir", ir_o, e.ir);
      end
    end
    if (reg_we_o === 1'b1) we_cnt++;
    if (trap_o === 1'b1 && !trap_seen) begin
      trap_seen = 1'b1;
      if (sbq.size() == 0) begin
        unexpected("trap_unexpected", {30'd0, trap_cause_o});
      end else begin
        e = sbq.pop_front();
        chk("trap_kind", {31'd0, e.is_trap}, 32'd1);
        chk("trap_cause", {30'd0, trap_cause_o}, {30'd0, e.cause});
        chk("trap_state", {29'd0, state_o}, {29'd0, S_TRAP});
        chk("trap_no_en", {30'd0, pc_en_o, reg_we_o}, 32'd0);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    observe();
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n;
    n = 0;
    while (state_o !== s && n < 60) begin
      cyc();
      n++;
    end
    chk(nm, {29'd0, state_o}, {29'd0, s});
  endtask

  task automatic do_reset(input logic hr);
    #1;
    chk("sb_drain", sbq.size(), 32'd0);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    imem_err = 1'b0;
    instr    = 32'd0;
    halt_req = hr;
    step_req = 1'b0;
    #2;
    chk("rst_state", {29'd0, state_o}, {29'd0, S_IDLE});
    chk("rst_ir", ir_o, 32'd0);
    chk("rst_retired", retired_o, 32'd0);
    chk("rst_outs", {24'd0, imem_req_o, ir_load_o, pc_en_o, reg_we_o, halted_o, trap_o, trap_cause_o}, 32'd0);
    sbq.delete();
    trap_seen = 1'b0;
    pc_cnt    = 0;
    we_cnt    = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait for FETCH, hold off 'waits' cycles (with a spurious unqualified error), then ack.
  task automatic issue(input logic [31:0] w, input int waits, input logic err_v,
                       input logic push, input exp_t e, output int c0);
    wait_state(S_FETCH, "to_fetch");
    c0 = cyc_n;
    chk("imem_req", {31'd0, imem_req_o}, 32'd1);
    imem_err = 1'b1;
    for (int k = 0; k < waits; k++) cyc();
    imem_ack = 1'b1;
    imem_err = err_v;
    instr    = w;
    if (push) sbq.push_back(e);
    cyc();
    imem_ack = 1'b0;
    imem_err = 1'b0;
    instr    = 32'hDEAD_BEEF;
    chk("ir_load", {31'd0, ir_load_o}, {31'd0, ~err_v});
    chk("ir", ir_o, err_v ? 32'd0 : w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   n;
    int   pc_before;
    exp_t e;

    tv[0] = '{32'h0020_8033, 0,  1'b0, 1'b0, 2'b00, 1'b0}; // add x0,x1,x2
    tv[1] = '{32'h0020_81B3, 3,  1'b0, 1'b0, 2'b00, 1'b1}; // add x3,x1,x2
    tv[2] = '{32'h0050_0093, 1,  1'b0, 1'b0, 2'b00, 1'b1}; // addi x1,x0,5
    tv[3] = '{32'h1234_5678, 2,  1'b1, 1'b1, 2'b01, 1'b0}; // fetch error
    tv[4] = '{32'h0000_0063, 0,  1'b0, 1'b1, 2'b11, 1'b0}; // beq: illegal here
    tv[5] = '{32'h0000_0013, 5,  1'b0, 1'b0, 2'b00, 1'b0}; // nop (addi x0)

    for (int i = 0; i < 6; i++) begin
      do_reset(1'b0);
      e = tv[i].trap ? mk_trap(tv[i].cause) : mk_ret(tv[i].instr, tv[i].we);
      issue(tv[i].instr, tv[i].waits, tv[i].err, 1'b1, e, c0);
      n = 0;
      while (state_o !== S_FETCH && state_o !== S_TRAP && n < 20) begin
        cyc();
        n++;
      end
      chk("vec_state", {29'd0, state_o}, tv[i].trap ? {29'd0, S_TRAP} : {29'd0, S_FETCH});
      chk("vec_trap", {31'd0, trap_o}, {31'd0, tv[i].trap});
      chk("vec_cause", {30'd0, trap_cause_o}, {30'd0, tv[i].cause});
      chk("vec_retired", retired_o, tv[i].trap ? 32'd0 : 32'd1);
      chk("vec_pc_en_cnt", pc_cnt, tv[i].trap ? 32'd0 : 32'd1);
      chk("vec_reg_we_cnt", we_cnt, {31'd0, tv[i].we});
      if (!tv[i].trap) chk("vec_wb_latency", wb_cyc - c0, tv[i].waits + 3);
    end

    // Fetch timeout: trap exactly TMO_MAX cycles after entering FETCH.
    do_reset(1'b0);
    wait_state(S_FETCH, "tmo_fetch");
    sbq.push_back(mk_trap(2'b10));
    repeat (TMO_MAX - 1) cyc();
    chk("tmo_not_yet", {29'd0, state_o}, {29'd0, S_FETCH});
    cyc();
    chk("tmo_state", {29'd0, state_o}, {29'd0, S_TRAP});
    chk("tmo_cause", {30'd0, trap_cause_o}, 32'd2);
    chk("tmo_req_off", {31'd0, imem_req_o}, 32'd0);
    // Trap is absorbing: debug requests and acks are ignored.
    halt_req = 1'b1;
    step_req = 1'b1;
    imem_ack = 1'b1;
    repeat (4) cyc();
    halt_req = 1'b0;
    step_req = 1'b0;
    imem_ack = 1'b0;
    chk("trap_hold_state", {29'd0, state_o}, {29'd0, S_TRAP});
    chk("trap_hold_cause", {30'd0, trap_cause_o}, 32'd2);
    chk("trap_hold_flags", {30'd0, trap_o, halted_o}, 32'd2);
    chk("trap_pc_cnt", pc_cnt, 32'd0);

    // Ack arriving on the expiry cycle beats the timeout.
    do_reset(1'b0);
    issue(32'h0020_81B3, TMO_MAX - 1, 1'b0, 1'b1, mk_ret(32'h0020_81B3, 1'b1), c0);
    wait_state(S_FETCH, "late_ack_done");
    chk("late_ack_trap", {31'd0, trap_o}, 32'd0);
    chk("late_ack_retired", retired_o, 32'd1);

    // Halt from IDLE, halt raised during EXEC, then single-stepping.
    do_reset(1'b1);
    cyc();
    chk("idle_to_halt", {29'd0, state_o}, {29'd0, S_HALT});
    chk("halted_flag", {31'd0, halted_o}, 32'd1);
    halt_req = 1'b0;
    cyc();
    chk("halt_release", {29'd0, state_o}, {29'd0, S_FETCH});
    issue(32'h00A0_0113, 0, 1'b0, 1'b1, mk_ret(32'h00A0_0113, 1'b1), c0);
    cyc();
    chk("in_exec", {29'd0, state_o}, {29'd0, S_EXEC});
    halt_req = 1'b1;
    cyc();
    chk("wb_completes", {29'd0, state_o}, {29'd0, S_WB});
    cyc();
    chk("halt_after_wb", {29'd0, state_o}, {29'd0, S_HALT});
    chk("halt_retired", retired_o, 32'd1);
    repeat (3) cyc();
    chk("halt_stays", {29'd0, state_o}, {29'd0, S_HALT});
    chk("halt_pc_cnt", pc_cnt, 32'd1);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    halt_req = 1'b0;
    chk("step_fetch", {29'd0, state_o}, {29'd0, S_FETCH});
    issue(32'h0020_81B3, 1, 1'b0, 1'b1, mk_ret(32'h0020_81B3, 1'b1), c0);
    wait_state(S_HALT, "step_rehalt");
    chk("step_retired", retired_o, 32'd2);
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    chk("step_prio", {29'd0, state_o}, {29'd0, S_FETCH});
    issue(32'h0000_0013, 0, 1'b0, 1'b1, mk_ret(32'h0000_0013, 1'b0), c0);
    wait_state(S_HALT, "step2_rehalt");
    chk("step2_retired", retired_o, 32'd3);
    cyc();
    chk("step_release", {29'd0, state_o}, {29'd0, S_FETCH});
    chk("step_we_cnt", we_cnt, 32'd2);
    chk("step_pc_cnt", pc_cnt, 32'd3);

    // Asynchronous reset in EXEC discards the instruction with no write-back.
    do_reset(1'b0);
    issue(32'h0020_81B3, 0, 1'b0, 1'b1, mk_ret(32'h0020_81B3, 1'b1), c0);
    wait_state(S_FETCH, "pre_rst_done");
    chk("pre_rst_retired", retired_o, 32'd1);
    issue(32'h0030_8233, 0, 1'b0, 1'b0, mk_ret(32'h0030_8233, 1'b1), c0);
    cyc();
    chk("rst_in_exec", {29'd0, state_o}, {29'd0, S_EXEC});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", {29'd0, state_o}, {29'd0, S_IDLE});
    chk("async_ir", ir_o, 32'd0);
    chk("async_retired", retired_o, 32'd0);
    chk("async_outs", {24'd0, imem_req_o, ir_load_o, pc_en_o, reg_we_o, halted_o, trap_o, trap_cause_o}, 32'd0);
    pc_before = pc_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("no_wb_after_rst", pc_cnt, pc_before);
    chk("post_rst_state", {29'd0, state_o}, {29'd0, S_FETCH});
    chk("post_rst_retired", retired_o, 32'd0);

    chk("sb_final", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
